// File: rtl/mmul2_index_gen.sv
// Index sequencer for the 2-matrix multiply: walks (i,j,k) with i outer, j middle, k inner.
// Latency: start to first valid is 1 cycle, last accept to done is 1 cycle; holds the tuple while ready=0.
// Optional stall counter output stall_cnt when MMUL2_IDX_PERF_EN is defined.
module mmul2_index_gen #(
    parameter int RA = 2,
    parameter int CA = 2,
    parameter int RB = 2,
    parameter int CB = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        clear,
    input  logic        ready,
    output logic        valid,
    output logic [31:0] i,
    output logic [31:0] j,
    output logic [31:0] k,
    output logic        last,
    output logic        busy,
    output logic        done
`ifdef MMUL2_IDX_PERF_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [31:0] RA_LAST = 32'(RA - 1);
    localparam logic [31:0] RB_LAST = 32'(RB - 1);
    localparam logic [31:0] CB_LAST = 32'(CB - 1);
    localparam logic        SINGLE  = (RA == 1) && (RB == 1) && (CB == 1);

    generate
        if (RA < 1 || RB < 1 || CB < 1 || CA != RB) begin : g_param_check
            $fatal(1, "mmul2_index_gen: need RA,RB,CB >= 1 and CA == RB");
        end
    endgenerate

    logic [1:0]  state;
    logic [31:0] i_nxt, j_nxt, k_nxt;
    logic        last_nxt;

    // Successor of the presented tuple; last is precomputed so it is registered with the tuple.
    always_comb begin
        i_nxt = i;
        j_nxt = j;
        k_nxt = k;
        if (k != RB_LAST) begin
            k_nxt = k + 32'd1;
        end else begin
            k_nxt = 32'd0;
            if (j != CB_LAST) begin
                j_nxt = j + 32'd1;
            end else begin
                j_nxt = 32'd0;
                i_nxt = i + 32'd1;
            end
        end
        last_nxt = (i_nxt == RA_LAST) && (j_nxt == CB_LAST) && (k_nxt == RB_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            valid <= 1'b0;
            last  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            i     <= 32'd0;
            j     <= 32'd0;
            k     <= 32'd0;
        end else if (clear) begin
            state <= S_IDLE;
            valid <= 1'b0;
            last  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            i     <= 32'd0;
            j     <= 32'd0;
            k     <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        valid <= 1'b1;
                        busy  <= 1'b1;
                        last  <= SINGLE;
                        i     <= 32'd0;
                        j     <= 32'd0;
                        k     <= 32'd0;
                    end
                end
                S_RUN: begin
                    if (ready) begin
                        if (last) begin
                            // Indices keep their final values through DONE.
                            state <= S_DONE;
                            valid <= 1'b0;
                            last  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            i    <= i_nxt;
                            j    <= j_nxt;
                            k    <= k_nxt;
                            last <= last_nxt;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    i     <= 32'd0;
                    j     <= 32'd0;
                    k     <= 32'd0;
                end
                default: begin
                    state <= S_IDLE;
                    valid <= 1'b0;
                    last  <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MMUL2_IDX_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 32'd0;
        end else if (clear || (state == S_IDLE && start)) begin
            stall_cnt <= 32'd0;
        end else if (state == S_RUN && valid && !ready && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
